// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between a queued keyboard source
// and a valid/ready host source. Define ARB_BURST_LOCK_EN to keep host bursts unsplit.
module uart_tx_arbiter #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned KBD_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kbdWrite,
   input  logic [DATA_W-1:0] kbdData,
   input  logic              hostValid,
   input  logic [DATA_W-1:0] hostData,
   input  logic              hostLast,
   output logic              hostReady,
   input  logic              fifoFull,
   output logic              fifoWriteRequest,
   output logic [DATA_W-1:0] fifoInData,
   output logic              kbdOverflow,
   input  logic              ovfClear
);

   localparam int unsigned PTR_W = $clog2(KBD_DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(KBD_DEPTH);

   logic [DATA_W-1:0] queue_mem [KBD_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    count;
   logic              last_host;
   logic              k_req;
   logic              h_req;
   logic              lock_active;
   logic              grant_kbd;
   logic              grant_host;
   logic              q_full;
   logic              push_ok;
   logic              drop;

`ifdef ARB_BURST_LOCK_EN
   typedef enum logic {StArb, StHostLock} state_t;
   state_t state;

   assign lock_active = (state == StHostLock);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= StArb;
      end else begin
         unique case (state)
            StArb:      if (grant_host && !hostLast) state <= StHostLock;
            StHostLock: if (grant_host && hostLast)  state <= StArb;
            default:    state <= StArb;
         endcase
      end
   end
`else
   logic unused_host_last;
   assign unused_host_last = hostLast;
   assign lock_active      = 1'b0;
`endif

   assign k_req = (count != '0);
   assign h_req = hostValid;

   // Grants already include the fifoFull gate, so a grant is a completed write.
   always_comb begin
      grant_kbd  = 1'b0;
      grant_host = 1'b0;
      if (!fifoFull) begin
         if (lock_active) begin
            grant_host = h_req;
         end else if (k_req && h_req) begin
            grant_kbd  = last_host;
            grant_host = !last_host;
         end else begin
            grant_kbd  = k_req;
            grant_host = h_req;
         end
      end
   end

   assign fifoWriteRequest = grant_kbd | grant_host;
   assign hostReady        = grant_host;
   assign fifoInData       = grant_host ? hostData : queue_mem[rd_ptr];

   // A same-cycle pop frees the slot, so a push at full only drops without a pop.
   assign q_full  = (count == FULL_COUNT);
   assign push_ok = kbdWrite & (!q_full | grant_kbd);
   assign drop    = kbdWrite & q_full & !grant_kbd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(KBD_DEPTH); i++) queue_mem[i] <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         last_host   <= 1'b1;
         kbdOverflow <= 1'b0;
      end else begin
         if (push_ok) begin
            queue_mem[wr_ptr] <= kbdData;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (grant_kbd) rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, grant_kbd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (fifoWriteRequest) last_host <= grant_host;
         if (drop)          kbdOverflow <= 1'b1;
         else if (ovfClear) kbdOverflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios push expected FIFO bytes,
// a negedge monitor pops and compares on every FIFO write.
module tb_uart_tx_arbiter;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned KBD_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              kbdWrite;
   logic [DATA_W-1:0] kbdData;
   logic              hostValid;
   logic [DATA_W-1:0] hostData;
   logic              hostLast;
   logic              hostReady;
   logic              fifoFull;
   logic              fifoWriteRequest;
   logic [DATA_W-1:0] fifoInData;
   logic              kbdOverflow;
   logic              ovfClear;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] sb [$];
   logic [7:0] mon_exp;

   uart_tx_arbiter #(
      .DATA_W    (DATA_W),
      .KBD_DEPTH (KBD_DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .kbdWrite         (kbdWrite),
      .kbdData          (kbdData),
      .hostValid        (hostValid),
      .hostData         (hostData),
      .hostLast         (hostLast),
      .hostReady        (hostReady),
      .fifoFull         (fifoFull),
      .fifoWriteRequest (fifoWriteRequest),
      .fifoInData       (fifoInData),
      .kbdOverflow      (kbdOverflow),
      .ovfClear         (ovfClear)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst || fifoFull) begin
         check("no_write_when_blocked", {30'd0, fifoWriteRequest, hostReady}, 32'd0);
      end else if (fifoWriteRequest) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got 0x%0h expected no write", fifoInData);
         end else begin
            mon_exp = sb.pop_front();
            check("fifo_data", {24'd0, fifoInData}, {24'd0, mon_exp});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      kbdWrite = 1'b1;
      kbdData  = d;
      tick();
      kbdWrite = 1'b0;
   endtask

   task automatic host_send(input logic [7:0] d, input logic last);
      bit done;
      done      = 1'b0;
      hostValid = 1'b1;
      hostData  = d;
      hostLast  = last;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (hostReady) done = 1'b1;
      end
      if (done) begin
         tick();
      end else begin
         n_checks++;
         $display("FAIL host_accept: byte 0x%0h not accepted within 60 cycles", d);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      tick();
      check(name, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      kbdWrite  = 1'b0;
      kbdData   = '0;
      hostValid = 1'b0;
      hostData  = '0;
      hostLast  = 1'b0;
      fifoFull  = 1'b0;
      ovfClear  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_write_req", {31'd0, fifoWriteRequest}, 32'd0);
      check("reset_host_ready", {31'd0, hostReady}, 32'd0);
      check("reset_overflow", {31'd0, kbdOverflow}, 32'd0);
      tick();

      // Keyboard-only bytes drain in push order.
      sb.push_back(8'h1C);
      sb.push_back(8'h32);
      push(8'h1C);
      push(8'h32);
      wait_drain("drain_kbd_only");

      // Fresh reset so KBD wins the first tie; fifoFull holds both sources off.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      fifoFull = 1'b1;
      sb.push_back(8'hAA);
      sb.push_back(8'h1B);
      sb.push_back(8'hBB);
      sb.push_back(8'h2B);
      fork
         begin
            host_send(8'h1B, 1'b1);
            host_send(8'h2B, 1'b1);
            hostValid = 1'b0;
         end
         begin
            push(8'hAA);
            push(8'hBB);
            repeat (5) tick();
            fifoFull = 1'b0;
         end
      join
      wait_drain("drain_alternate");

      // Overflow: five pushes into a full queue, the fifth with ovfClear (set wins).
      fifoFull = 1'b1;
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      ovfClear = 1'b1;
      push(8'h05);
      ovfClear = 1'b0;
      @(negedge clk);
      check("overflow_set", {31'd0, kbdOverflow}, 32'd1);
      tick();
      ovfClear = 1'b1;
      tick();
      ovfClear = 1'b0;
      @(negedge clk);
      check("overflow_cleared", {31'd0, kbdOverflow}, 32'd0);
      tick();
      // Release with a push at count==KBD_DEPTH: the pop makes room.
      sb.push_back(8'h01);
      sb.push_back(8'h02);
      sb.push_back(8'h03);
      sb.push_back(8'h04);
      sb.push_back(8'h06);
      fifoFull = 1'b0;
      push(8'h06);
      wait_drain("drain_after_overflow");
      check("no_overflow_on_push_pop", {31'd0, kbdOverflow}, 32'd0);

      // Host burst versus a keyboard byte; last grant was KBD.
      fifoFull = 1'b1;
`ifdef ARB_BURST_LOCK_EN
      sb.push_back(8'h1B);
      sb.push_back(8'h5B);
      sb.push_back(8'h41);
      sb.push_back(8'h61);
`else
      sb.push_back(8'h1B);
      sb.push_back(8'h61);
      sb.push_back(8'h5B);
      sb.push_back(8'h41);
`endif
      fork
         begin
            host_send(8'h1B, 1'b0);
            host_send(8'h5B, 1'b0);
            host_send(8'h41, 1'b1);
            hostValid = 1'b0;
            hostLast  = 1'b0;
         end
         begin
            push(8'h61);
            tick();
            tick();
            fifoFull = 1'b0;
         end
      join
      wait_drain("drain_burst");

      // Reset with three queued bytes: they must vanish.
      fifoFull = 1'b1;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      fifoFull = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("idle_after_reset", {31'd0, fifoWriteRequest}, 32'd0);
      end
      tick();
      sb.push_back(8'h7E);
      push(8'h7E);
      wait_drain("drain_after_reset");

      check("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
